// File: rtl/nco_carrier_gen.sv
// Quadrature NCO: phase accumulator, quarter-wave fold and signed cos/sin output.
// A single quarter table serves both outputs through symmetry.
module nco_carrier_gen #(
  parameter int PHASE_W = 16,
  parameter int IDX_W   = 3,
  parameter int AMP_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sync,
  input  logic               fcw_we,
  input  logic [PHASE_W-1:0] fcw,
  input  logic               poff_we,
  input  logic [PHASE_W-1:0] poff,
  output logic [AMP_W-1:0]   cos,
  output logic [AMP_W-1:0]   sin,
  output logic               valid,
  output logic               wrap
);

  localparam int QN = 1 << (IDX_W - 2);
  localparam int AW = IDX_W - 1;
  localparam longint AMP_A = (64'sd1 <<< (AMP_W - 1)) - 64'sd1;
  localparam logic [PHASE_W-1:0] FCW_RST = PHASE_W'(1) << (PHASE_W - IDX_W);
  localparam logic [AW-1:0] QN_A = AW'(QN);

  // Quarter cosine table in Q30 fixed point via Taylor series, rounded half away from zero
  function automatic logic [(QN+1)*AMP_W-1:0] build_qtab();
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint val;
    build_qtab = '0;
    for (int k = 0; k <= QN; k++) begin
      x    = (64'sd1686629713 * longint'(k)) / longint'(QN);
      x2   = (x * x) >>> 6'd30;
      term = 64'sd1 <<< 6'd30;
      sum  = term;
      for (int n = 1; n <= 10; n++) begin
        term = -(((term * x2) >>> 6'd30) / longint'(2 * n * (2 * n - 1)));
        sum  = sum + term;
      end
      val = (sum * AMP_A + (64'sd1 <<< 6'd29)) >>> 6'd30;
      val = (val < 64'sd0) ? 64'sd0 : val;
      build_qtab[k*AMP_W +: AMP_W] = val[AMP_W-1:0];
    end
  endfunction

  localparam logic [(QN+1)*AMP_W-1:0] QTAB = build_qtab();

  logic [PHASE_W-1:0] fcw_r, poff_r, acc_r, ph_r;
  logic               v0_r, w0_r, v1_r, w1_r;
  logic [1:0]         q_r;
  logic [AW-1:0]      r_r, m_r;
  logic [AMP_W-1:0]   cos_r, sin_r;
  logic               valid_r, wrap_r;

  logic [PHASE_W:0]   sum_s;
  logic [PHASE_W-1:0] ph_s;
  logic [IDX_W-1:0]   idx_s;
  logic [AW-1:0]      r_s;
  logic [AMP_W-1:0]   c_s, s_s, cos_n_s, sin_n_s;

  assign sum_s = {1'b0, acc_r} + {1'b0, fcw_r};
  assign ph_s  = (sync ? {PHASE_W{1'b0}} : acc_r) + poff_r;
  assign idx_s = ph_r[PHASE_W-1 -: IDX_W];
  assign r_s   = AW'(idx_s[IDX_W-3:0]);

  generate
    if (IDX_W < PHASE_W) begin : g_low
      logic unused_s;
      assign unused_s = ^ph_r[PHASE_W-IDX_W-1:0];
    end
  endgenerate

  // Frequency and phase-offset registers, writable regardless of en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcw_r  <= FCW_RST;
      poff_r <= {PHASE_W{1'b0}};
    end else begin
      if (fcw_we) fcw_r <= fcw;
      if (poff_we) poff_r <= poff;
    end
  end

  // Stage 0: accumulator update and phase launch; sync restarts from zero with the old fcw
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= {PHASE_W{1'b0}};
      ph_r  <= {PHASE_W{1'b0}};
      v0_r  <= 1'b0;
      w0_r  <= 1'b0;
    end else begin
      v0_r <= en;
      if (en) begin
        ph_r <= ph_s;
        if (sync) begin
          acc_r <= fcw_r;
          w0_r  <= 1'b0;
        end else begin
          acc_r <= sum_s[PHASE_W-1:0];
          w0_r  <= sum_s[PHASE_W];
        end
      end else begin
        w0_r <= 1'b0;
        if (sync) acc_r <= {PHASE_W{1'b0}};
      end
    end
  end

  // Stage 1: quadrant, table address and its mirror
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      w1_r <= 1'b0;
      q_r  <= 2'd0;
      r_r  <= {AW{1'b0}};
      m_r  <= {AW{1'b0}};
    end else begin
      v1_r <= v0_r;
      w1_r <= w0_r;
      q_r  <= idx_s[IDX_W-1 -: 2];
      r_r  <= r_s;
      m_r  <= QN_A - r_s;
    end
  end

  // Quadrant unfolding of the quarter-table values
  always_comb begin
    c_s     = QTAB[int'(r_r)*AMP_W +: AMP_W];
    s_s     = QTAB[int'(m_r)*AMP_W +: AMP_W];
    cos_n_s = c_s;
    sin_n_s = s_s;
    case (q_r)
      2'd0: begin cos_n_s = c_s;  sin_n_s = s_s;  end
      2'd1: begin cos_n_s = -s_s; sin_n_s = c_s;  end
      2'd2: begin cos_n_s = -c_s; sin_n_s = -s_s; end
      2'd3: begin cos_n_s = s_s;  sin_n_s = -c_s; end
      default: begin cos_n_s = c_s; sin_n_s = s_s; end
    endcase
  end

  // Stage 2: outputs hold their last sample while no new one arrives
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cos_r   <= {AMP_W{1'b0}};
      sin_r   <= {AMP_W{1'b0}};
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      valid_r <= v1_r;
      wrap_r  <= w1_r;
      if (v1_r) begin
        cos_r <= cos_n_s;
        sin_r <= sin_n_s;
      end
    end
  end

  assign cos   = cos_r;
  assign sin   = sin_r;
  assign valid = valid_r;
  assign wrap  = wrap_r;

endmodule
